cmp_mask_packer: RTL
====================

Name: cmp_mask_packer

Overview:
- Downstream consumer of the per-lane comparator outputs in the ALU datapath.
- Collects LANES comparison results per beat and packs them into a MASK_W-bit destination mask. Used for the vector mask-compare ops: vmslt, vmsle, vmsgt, vmsge.
- Applies mask-undisturbed rules for inactive elements and tail rules for elements at or beyond vl.
- Gates the comparator lane enables and hands the finished mask to register writeback over a valid/ready handshake.

Parameters:
- LANES, 4, comparator lanes delivered per beat.
- MASK_W, 32, maximum elements and mask width. Must be a multiple of LANES.
- VL_W, $clog2(MASK_W+1), width of vl_i.

Ports:
- module_clk_i  in  1  block clock.
- module_rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that begins an op. Honoured only in IDLE.
- vl_i  in  VL_W  active element count, 0..MASK_W. Sampled on start.
- vm_i  in  1  1 = unmasked, 0 = use v0_i as element mask. Sampled on start.
- v0_i  in  MASK_W  element mask. Sampled on start.
- old_mask_i  in  MASK_W  prior destination value. Sampled on start.
- sel_ge_gt_i  in  1  0 = take lt_le lane bits, 1 = take ge_gt lane bits. Sampled on start.
- beat_valid_i  in  1  current lane results are valid.
- lt_le_i  in  LANES  per-lane LT_LE comparator outputs.
- ge_gt_i  in  LANES  per-lane GE_GT comparator outputs.
- cmp_en_o  out  LANES  per-lane comparator enable.
- busy_o  out  1  high when not IDLE.
- mask_o  out  MASK_W  packed result.
- mask_valid_o  out  1  result available.
- mask_ready_i  in  1  writeback accepts the result.

Behaviour:
- Reset values (async, module_rst_ni=0):
  - state=IDLE, elem_idx=0, all captured registers 0.
  - mask_o=0, mask_valid_o=0, busy_o=0, cmp_en_o=0.
- States:
  - IDLE: start_i=1 captures vl/vm/v0/old_mask/sel and loads mask_r=old_mask_i. Goes to COLLECT if vl_i>0, else DONE with mask_r=old_mask_i.
  - COLLECT: each beat_valid_i=1 cycle writes lanes j=0..LANES-1 to element e=elem_idx+j, then elem_idx += LANES.
    - If elem_idx+LANES >= vl_r on that beat, go to DONE in the next cycle.
    - Cycles with beat_valid_i=0 are stalls with no change.
  - DONE: mask_valid_o=1 and mask_o=mask_r, held stable until mask_ready_i=1. On that cycle go to IDLE, and mask_valid_o drops the next cycle.
- Element write rule for element e in a beat:
  - res = sel_r ? ge_gt_i[j] : lt_le_i[j].
  - If e >= vl_r, it is a tail element: keep old bit (see optional feature).
  - Else if vm_r=0 and v0_r[e]=0, it is an inactive element: keep old bit.
  - Else mask_r[e] = res.
- cmp_en_o[j]:
  - High only in COLLECT, and only when lane element e < vl_r and (vm_r=1 or v0_r[e]=1).
  - Otherwise 0, so idle and inactive comparator lanes see zeroed operands.
- Output timing:
  - mask_o is registered and equals mask_r in all states. It holds its last value after handshake until the next start.
  - Latency: vl>0 gives ceil(vl/LANES) valid beats plus 1 cycle to mask_valid_o. vl=0 gives mask_valid_o 1 cycle after start.
- Boundary conditions:
  - start_i outside IDLE is ignored. No restart mid-op.
  - beat_valid_i in IDLE or DONE is ignored.
  - vl_i > MASK_W is clamped to MASK_W.
  - Start on the same cycle as the DONE handshake is ignored, because state is not yet IDLE.
  - Reset mid-op aborts immediately to IDLE with outputs at their reset values. No partial mask is emitted.

Optional Feature:
- Macro: CMP_MASK_TAIL_AGN_EN.
- Defined: tail-agnostic. Elements e >= vl_r are written as 1 in mask_r, and with vl=0, mask_o is all ones. Inactive (masked-off) elements still keep old bits.
- Undefined: tail-undisturbed. Tail elements keep old_mask bits.

Test Plan:
- LANES=4, vl=8, vm=1, sel=0, old=0, beats lt_le=4'b1010 then 4'b0110 -> mask_o=32'h0000_006A, mask_valid_o 3 cycles after start with no stalls.
- vl=6, vm=1, sel=1, old=32'hFFFF_FF00, beats ge_gt=4'b0000, 4'b1100 -> mask_o=32'hFFFF_FF00 (elements 6,7 tail kept). With TAIL_AGN_EN -> 32'hFFFF_FFC0.
- vl=4, vm=0, v0=32'h5, old=32'hA, beat lt_le=4'b1111 -> mask_o=32'hF, and cmp_en_o=4'b0101 during COLLECT.
- vl=0, old=32'h1234_5678 -> mask_valid_o next cycle with mask_o=32'h1234_5678. Hold mask_ready_i=0 for 5 cycles -> valid and data stable, then IDLE after ready.
- Stalls plus ignored start: insert beat_valid_i=0 gaps and pulse start_i in COLLECT -> result identical to the no-stall case and captured fields unchanged.
- Assert module_rst_ni low after 1 of 2 beats -> all outputs 0 asynchronously. A new op after reset produces a correct, independent mask.

Source files
------------

// File: rtl/cmp_mask_packer.sv
// Packs per-lane compare results into a destination mask for vmslt/vmsle/vmsgt/vmsge.
// Define CMP_MASK_TAIL_AGN_EN for tail-agnostic (tail written as ones) behaviour.
module cmp_mask_packer #(
  parameter int LANES  = 4,
  parameter int MASK_W = 32,
  parameter int VL_W   = $clog2(MASK_W + 1)
) (
  input  logic              module_clk_i,
  input  logic              module_rst_ni,
  input  logic              start_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic              vm_i,
  input  logic [MASK_W-1:0] v0_i,
  input  logic [MASK_W-1:0] old_mask_i,
  input  logic              sel_ge_gt_i,
  input  logic              beat_valid_i,
  input  logic [LANES-1:0]  lt_le_i,
  input  logic [LANES-1:0]  ge_gt_i,
  output logic [LANES-1:0]  cmp_en_o,
  output logic              busy_o,
  output logic [MASK_W-1:0] mask_o,
  output logic              mask_valid_o,
  input  logic              mask_ready_i
);

  localparam int EW    = (MASK_W > 1) ? $clog2(MASK_W) : 1;
  localparam int IDX_W = VL_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    elem_idx_q, elem_idx_d;
  logic [VL_W-1:0]     vl_q, vl_d;
  logic                vm_q, vm_d;
  logic [MASK_W-1:0]   v0_q, v0_d;
  logic                sel_q, sel_d;
  logic [MASK_W-1:0]   mask_q, mask_d;

  logic [VL_W-1:0]     vl_c;
  logic [IDX_W-1:0]    next_idx;
  logic [EW-1:0]       lane_idx [LANES];
  logic [LANES-1:0]    lane_in_vl;
  logic [LANES-1:0]    lane_act;
  logic [LANES-1:0]    lane_res;

  // Requests longer than the mask are clamped to the full mask.
  always_comb begin
    vl_c = vl_i;
    if (vl_i > VL_W'(MASK_W)) begin
      vl_c = VL_W'(MASK_W);
    end
  end

`ifdef CMP_MASK_TAIL_AGN_EN
  logic [MASK_W-1:0] tail_c;

  always_comb begin
    tail_c = '0;
    for (int i = 0; i < MASK_W; i++) begin
      tail_c[i] = (IDX_W'(i) >= {1'b0, vl_c});
    end
  end
`endif

  always_comb begin
    lane_in_vl = '0;
    lane_act   = '0;
    lane_res   = sel_q ? ge_gt_i : lt_le_i;
    for (int j = 0; j < LANES; j++) begin
      lane_idx[j]   = elem_idx_q[EW-1:0] + EW'(j);
      lane_in_vl[j] = (elem_idx_q + IDX_W'(j)) < {1'b0, vl_q};
      lane_act[j]   = lane_in_vl[j] &&
                      (vm_q || v0_q[lane_idx[j]]);
    end
  end

  assign next_idx = elem_idx_q + IDX_W'(LANES);

  always_comb begin
    state_d    = state_q;
    elem_idx_d = elem_idx_q;
    vl_d       = vl_q;
    vm_d       = vm_q;
    v0_d       = v0_q;
    sel_d      = sel_q;
    mask_d     = mask_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          vl_d       = vl_c;
          vm_d       = vm_i;
          v0_d       = v0_i;
          sel_d      = sel_ge_gt_i;
          elem_idx_d = '0;
`ifdef CMP_MASK_TAIL_AGN_EN
          mask_d     = old_mask_i | tail_c;
`else
          mask_d     = old_mask_i;
`endif
          state_d    = (vl_c != '0) ? S_COLLECT : S_DONE;
        end
      end
      S_COLLECT: begin
        if (beat_valid_i) begin
          for (int j = 0; j < LANES; j++) begin
            if (lane_act[j]) begin
              mask_d[lane_idx[j]] = lane_res[j];
`ifdef CMP_MASK_TAIL_AGN_EN
            end else if (!lane_in_vl[j]) begin
              mask_d[lane_idx[j]] = 1'b1;
`endif
            end
          end
          elem_idx_d = next_idx;
          if (next_idx >= {1'b0, vl_q}) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (mask_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
    if (!module_rst_ni) begin
      state_q    <= S_IDLE;
      elem_idx_q <= '0;
      vl_q       <= '0;
      vm_q       <= 1'b0;
      v0_q       <= '0;
      sel_q      <= 1'b0;
      mask_q     <= '0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      vl_q       <= vl_d;
      vm_q       <= vm_d;
      v0_q       <= v0_d;
      sel_q      <= sel_d;
      mask_q     <= mask_d;
    end
  end

  // Enables are zero outside COLLECT so idle lanes see zeroed operands.
  assign cmp_en_o     = (state_q == S_COLLECT) ? lane_act : '0;
  assign busy_o       = (state_q != S_IDLE);
  assign mask_valid_o = (state_q == S_DONE);
  assign mask_o       = mask_q;

endmodule
